// File: rtl/fetch_stage.sv
// fetch_stage
//   Instruction-fetch stage placed directly in front of the instruction ROM.
//   It owns the PC and drives the ROM enable and address. The ROM returns its
//   big-endian word combinationally in the same cycle, and the stage captures
//   that word into a small fetch queue. The queue head goes to decode as
//   {pc, inst, adel} over a valid/ready handshake.
//
//   A misaligned PC does not read the ROM. Instead it produces a single
//   address-error entry (adel=1, inst=0), and fetch halts until the next
//   redirect.
//
// Parameters
//   RESET_PC  PC loaded on reset
//   DEPTH     fetch-queue entries (power of two, >= 2)
//
// Ports
//   clk, rst                       clock (rising edge), async active-high reset
//   rom_en / rom_addr / rom_inst   ROM read port; rom_addr always equals the PC
//   flush / flush_pc               exception redirect (wins over branch)
//   branch_taken / branch_target   branch redirect
//   id_ready                       decode accepts the head entry
//   id_valid/id_pc/id_inst/id_adel registered queue head presented to decode
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        rom_en,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_inst,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_adel
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [AW:0] FULL    = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_1 = AW'(1);
  localparam logic [AW:0] CNT_1   = (AW+1)'(1);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t        state, state_nxt;
  logic [31:0]   pc, pc_nxt;

  logic [31:0]   q_pc   [DEPTH];
  logic [31:0]   q_inst [DEPTH];
  logic          q_adel [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;

  logic          redirect;
  logic [31:0]   target;
  logic          aligned;
  logic          push;
  logic          push_adel;
  logic          pop;

  // ---------------------------------------------------------------------------
  // Redirect selection: an exception flush overrides a branch.
  // ---------------------------------------------------------------------------
  assign redirect = flush | branch_taken;
  assign target   = flush ? flush_pc : branch_target;
  assign aligned  = (pc[1:0] == 2'b00);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state. A redirect always resumes fetch. Pushing an address-error
  // entry parks the stage in HALT.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    if (redirect) begin
      state_nxt = RUN;
    end else if (push_adel) begin
      state_nxt = HALT;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs. A push is allowed when there is room, or when the head
  // leaves the queue in the same cycle. The push term is gated with rst
  // because reset is asynchronous: the ROM must stay idle while rst is held
  // high, even though the registers already show RUN with an empty queue.
  // ---------------------------------------------------------------------------
  always_comb begin
    push      = 1'b0;
    rom_en    = 1'b0;
    push_adel = 1'b0;
    if (!rst && state == RUN && !redirect &&
        ((count < FULL) || (id_valid && id_ready))) begin
      push = 1'b1;
    end
    rom_en    = push & aligned;
    push_adel = push & ~aligned;
  end

  assign rom_addr = pc;

  // ---------------------------------------------------------------------------
  // Program counter
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_nxt = pc;
    if (redirect) begin
      pc_nxt = target;
    end else if (rom_en) begin
      pc_nxt = pc + 32'd4;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Fetch queue. On a redirect, the contents are discarded by resetting the
  // pointers and the count; stale storage is never visible because id_valid
  // follows the count. A pop requested during a redirect cycle is ignored,
  // since decode is being flushed anyway.
  // ---------------------------------------------------------------------------
  assign pop = id_valid & id_ready & ~redirect;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_pc   <= '{default: '0};
      q_inst <= '{default: '0};
      q_adel <= '{default: 1'b0};
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redirect) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        q_pc[wr_ptr]   <= pc;
        q_inst[wr_ptr] <= aligned ? rom_inst : '0;
        q_adel[wr_ptr] <= ~aligned;
        wr_ptr         <= wr_ptr + PTR_1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_1;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_1;
        2'b01:   count <= count - CNT_1;
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Decode-facing outputs come straight from the head register, so they stay
  // stable while decode stalls.
  // ---------------------------------------------------------------------------
  assign id_valid = (count != '0);
  assign id_pc    = q_pc[rd_ptr];
  assign id_inst  = q_inst[rd_ptr];
  assign id_adel  = q_adel[rd_ptr];

endmodule
